// File: rtl/nf_router_pkg.sv
// Shared types and the slave address map for the nf_router data-bus router.
// The map is fixed here; the top only exposes the first SLV_NUM entries.
package nf_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int unsigned MAX_SLV = 4;

    // Slot order is priority order: RAM, GPIO, UART, Timer.
    localparam logic [31:0] BASE [MAX_SLV] = '{
        32'h0000_0000,
        32'h0001_0000,
        32'h0002_0000,
        32'h0003_0000
    };

    localparam logic [31:0] MASK [MAX_SLV] = '{
        32'hFFFF_0000,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_FF00
    };

    function automatic logic addr_hit(input logic [31:0] addr, input logic [1:0] idx);
        return (addr & MASK[idx]) == BASE[idx];
    endfunction

endpackage

// File: rtl/nf_router_if.sv
// Bus bundle between CPU data port, nf_router and its slaves.
// master: the router's view; slave: the view of the CPU plus slave devices.
interface nf_router_if #(
    parameter int unsigned SLV_NUM = 4
);

    logic [31:0]           addr_dm;
    logic                  we_dm;
    logic [31:0]           wd_dm;
    logic                  req_dm;
    logic [31:0]           rd_dm;
    logic                  req_ack_dm;
    logic                  bus_err;

    logic [31:0]           addr_s;
    logic                  we_s;
    logic [31:0]           wd_s;
    logic [SLV_NUM-1:0]    req_s;
    logic [SLV_NUM-1:0]    ack_s;
    logic [32*SLV_NUM-1:0] rd_s;

    modport master (
        input  addr_dm, we_dm, wd_dm, req_dm, ack_s, rd_s,
        output rd_dm, req_ack_dm, bus_err, addr_s, we_s, wd_s, req_s
    );

    modport slave (
        output addr_dm, we_dm, wd_dm, req_dm, ack_s, rd_s,
        input  rd_dm, req_ack_dm, bus_err, addr_s, we_s, wd_s, req_s
    );

endinterface

// File: rtl/nf_router_dec.sv
// Combinational address decoder: one-hot slave select plus unmapped flag.
// Lowest matching slot wins when regions overlap.
module nf_router_dec
    import nf_router_pkg::*;
#(
    parameter int unsigned SLV_NUM = 4
) (
    input  logic [31:0]        addr,
    output logic [SLV_NUM-1:0] sel,
    output logic               unmapped
);

    always_comb begin
        sel      = '0;
        unmapped = 1'b1;
        for (int unsigned k = 0; k < SLV_NUM; k++) begin
            if (unmapped && addr_hit(addr, 2'(k))) begin
                sel[k]   = 1'b1;
                unmapped = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nf_router.sv
// nf_router: routes CPU data requests to one of SLV_NUM slaves over req/ack.
// Define NF_ROUTER_TIMEOUT_EN to abort slave accesses that stall in WAIT.
module nf_router
    import nf_router_pkg::*;
#(
    parameter int unsigned SLV_NUM     = 4,
    parameter logic [31:0] ERR_DATA    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       resetn,
    nf_router_if.master bus
);

    state_t             state;
    state_t             state_nxt;
    logic [SLV_NUM-1:0] dec_sel;
    logic               dec_unmapped;
    logic [SLV_NUM-1:0] sel_q;
    logic               err_q;
    logic               ack_hit;
    logic               timeout;
    logic [31:0]        rd_sel;

    nf_router_dec #(
        .SLV_NUM (SLV_NUM)
    ) u_dec (
        .addr     (bus.addr_dm),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // Only the latched slave's ack counts; the FSM looks at it in WAIT only.
    assign ack_hit = |(bus.ack_s & sel_q);

    always_comb begin
        rd_sel = '0;
        for (int unsigned k = 0; k < SLV_NUM; k++) begin
            if (sel_q[k]) begin
                rd_sel = bus.rd_s[32*k +: 32];
            end
        end
    end

`ifdef NF_ROUTER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_s      = '0;
        bus.req_ack_dm = 1'b0;
        bus.bus_err    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_dm) begin
                    state_nxt = dec_unmapped ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.req_s = sel_q;
                if (ack_hit || timeout) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.req_ack_dm = 1'b1;
                bus.bus_err    = err_q;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A completing ack takes priority over a timeout in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.addr_s <= '0;
            bus.we_s   <= 1'b0;
            bus.wd_s   <= '0;
            bus.rd_dm  <= '0;
            sel_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_dm) begin
                        if (dec_unmapped) begin
                            bus.rd_dm <= ERR_DATA;
                            err_q     <= 1'b1;
                        end else begin
                            bus.addr_s <= bus.addr_dm;
                            bus.we_s   <= bus.we_dm;
                            bus.wd_s   <= bus.wd_dm;
                            sel_q      <= dec_sel;
                            err_q      <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        bus.rd_dm <= rd_sel;
                    end else if (timeout) begin
                        bus.rd_dm <= ERR_DATA;
                        err_q     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf_router.sv
// Scoreboard bench for nf_router: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever req_ack_dm is seen.
module tb_nf_router;

    localparam int unsigned SLV      = 4;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t exp_q [$];
    int unsigned n_vec;
    int unsigned n_err;
    logic in_done;
    logic prev_ack;

    nf_router_if #(.SLV_NUM(SLV)) bus ();

    nf_router #(
        .SLV_NUM     (SLV),
        .ERR_DATA    (ERR_DATA),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference address map written as plain address ranges.
    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a >= 32'h0001_0000 && a <= 32'h0001_00FF) return 1;
        if (a >= 32'h0002_0000 && a <= 32'h0002_00FF) return 2;
        if (a >= 32'h0003_0000 && a <= 32'h0003_00FF) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return {16'h0000, 16'($urandom)};
            1:       return 32'h0001_0000 | 32'($urandom_range(0, 255));
            2:       return 32'h0002_0000 | 32'($urandom_range(0, 255));
            3:       return 32'h0003_0000 | 32'($urandom_range(0, 255));
            4:       return (32'($urandom_range(1, 6)) << 16) | 32'($urandom_range(0, 511));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            prev_ack = 1'b0;
        end else begin
            if (bus.req_ack_dm) begin
                if (prev_ack) begin
                    n_err++;
                    $display("FAIL ack_pulse: req_ack_dm high, expected one-cycle pulse at %0t", $time);
                end
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: req_ack_dm=1, expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_dm", bus.rd_dm, e.rd);
                    check("bus_err", {31'b0, bus.bus_err}, {31'b0, e.err});
                end
            end else if (bus.bus_err) begin
                n_err++;
                $display("FAIL err_alone: bus_err=1 without req_ack_dm, expected 0 at %0t", $time);
            end
            prev_ack = bus.req_ack_dm;
        end
    end

    task automatic gap(input int unsigned g);
        if (g > 0) begin
            bus.req_dm = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            in_done = 1'b0;
        end
    endtask

    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input int unsigned dly, input logic stray, input logic [31:0] data);
        int s;
        logic [SLV-1:0] oh;
        s = ref_slave(a);
        exp_q.push_back(exp_t'{rd: (s < 0) ? ERR_DATA : data, err: (s < 0)});
        bus.addr_dm = a;
        bus.we_dm   = w;
        bus.wd_dm   = d;
        bus.req_dm  = 1'b1;
        if (in_done) begin
            @(posedge clk);
            #1;
            check("done_ignores_req", {31'b0, bus.req_ack_dm}, 32'd0);
            check("done_req_s", {28'b0, bus.req_s}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (s < 0) begin
            check("unmap_ack", {31'b0, bus.req_ack_dm}, 32'd1);
            check("unmap_req_s", {28'b0, bus.req_s}, 32'd0);
        end else begin
            oh = SLV'(1) << s;
            for (int i = 0; i <= int'(dly); i++) begin
                check("wait_req_s", {28'b0, bus.req_s}, {28'b0, oh});
                check("wait_no_ack", {31'b0, bus.req_ack_dm}, 32'd0);
                check("addr_s", bus.addr_s, a);
                check("we_s", {31'b0, bus.we_s}, {31'b0, w});
                check("wd_s", bus.wd_s, d);
                bus.rd_s = {$urandom, $urandom, $urandom, $urandom};
                if (i == int'(dly)) begin
                    bus.ack_s = oh;
                    bus.rd_s[32*s +: 32] = data;
                end else begin
                    bus.ack_s = stray ? ~oh : '0;
                end
                @(posedge clk);
                #1;
            end
            bus.ack_s = '0;
            check("ack_latency", {31'b0, bus.req_ack_dm}, 32'd1);
            check("req_s_dropped", {28'b0, bus.req_s}, 32'd0);
        end
        bus.req_dm = 1'b0;
        in_done    = 1'b1;
    endtask

    task automatic reset_mid();
        bus.addr_dm = 32'h0000_0100;
        bus.we_dm   = 1'b1;
        bus.wd_dm   = 32'hDEAD_BEEF;
        bus.req_dm  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pre_req_s", {28'b0, bus.req_s}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_req_s", {28'b0, bus.req_s}, 32'd0);
        check("rst_no_ack", {31'b0, bus.req_ack_dm}, 32'd0);
        check("rst_addr_s", bus.addr_s, 32'd0);
        check("rst_we_s", {31'b0, bus.we_s}, 32'd0);
        bus.req_dm = 1'b0;
        @(posedge clk);
        #1;
        resetn  = 1'b1;
        in_done = 1'b0;
        gap(1);
    endtask

`ifdef NF_ROUTER_TIMEOUT_EN
    task automatic do_noack();
        int unsigned hi;
        logic seen;
        exp_q.push_back(exp_t'{rd: ERR_DATA, err: 1'b1});
        bus.addr_dm = 32'h0002_0010;
        bus.we_dm   = 1'b0;
        bus.req_dm  = 1'b1;
        bus.ack_s   = '0;
        hi   = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.req_s[2]) hi++;
            if (bus.req_ack_dm) seen = 1'b1;
        end
        check("tmo_seen", {31'b0, seen}, 32'd1);
        check("tmo_req_cycles", hi, 32'd16);
        bus.req_dm = 1'b0;
        in_done    = seen;
    endtask
`endif

    initial begin
        n_vec       = 0;
        n_err       = 0;
        in_done     = 1'b0;
        prev_ack    = 1'b0;
        resetn      = 1'b0;
        bus.addr_dm = 32'h0000_0010;
        bus.we_dm   = 1'b1;
        bus.wd_dm   = 32'hFFFF_FFFF;
        bus.req_dm  = 1'b1;
        bus.ack_s   = '1;
        bus.rd_s    = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_dm", bus.rd_dm, 32'd0);
        check("reset_req_ack", {31'b0, bus.req_ack_dm}, 32'd0);
        check("reset_bus_err", {31'b0, bus.bus_err}, 32'd0);
        check("reset_addr_s", bus.addr_s, 32'd0);
        check("reset_we_s", {31'b0, bus.we_s}, 32'd0);
        check("reset_wd_s", bus.wd_s, 32'd0);
        check("reset_req_s", {28'b0, bus.req_s}, 32'd0);
        bus.req_dm = 1'b0;
        bus.ack_s  = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        gap(1);

        do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678);
        gap(1);
        do_txn(32'h0001_0004, 1'b1, 32'h0000_00A5, 3, 1'b0, $urandom);
        gap(1);
        do_txn(32'h0009_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        gap(1);
        do_txn(32'h0000_0040, 1'b0, 32'h0, 4, 1'b1, 32'hCAFE_0001);
        do_txn(32'h0000_FFFF, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
        do_txn(32'h0001_0100, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        do_txn(32'h0001_00FF, 1'b1, 32'h7777_0000, 2, 1'b1, 32'h1111_2222);
        do_txn(32'h0003_00FF, 1'b0, 32'h0, 0, 1'b0, 32'h3333_4444);
        do_txn(32'h0004_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        gap(1);

        reset_mid();
        do_txn(32'h0002_0008, 1'b0, 32'h0, 2, 1'b0, 32'h5A5A_A5A5);
        gap(1);

`ifdef NF_ROUTER_TIMEOUT_EN
        do_noack();
        gap(2);
`endif

        for (int t = 0; t < 80; t++) begin
            do_txn(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 6),
                   1'($urandom), $urandom);
            gap($urandom_range(0, 2));
        end

        gap(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
